io_bus_responder: RTL and testbench
===================================

Name: io_bus_responder

Overview:
- Memory-mapped peripheral on the CPU data bus. It is the responder end of the CPU's Databus/Write/data_in interface.
- Decodes a word address and accepts CPU writes from Databus on Write.
- Returns registered read data on data_in one cycle after Read.
- Hosts a GPIO output latch, a synchronized GPIO input, a receive FIFO fed by an external source, and a one-shot down-counter timer with an interrupt.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2.
- GPIO_WIDTH, 16, width of the GPIO in/out ports; at most 64.
- ADDR_W, 8, width of the address input.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  byte address from the datapath; bits [2:0] are ignored.
- Databus  in  64  CPU write data.
- Write  in  1  write strobe, one word per cycle.
- Read  in  1  read strobe.
- data_in  out  64  read data returned to the CPU.
- gpio_out  out  GPIO_WIDTH  output latch.
- gpio_in  in  GPIO_WIDTH  asynchronous external inputs.
- rx_data  in  64  external receive word.
- rx_valid  in  1  source has a word.
- rx_ready  out  1  FIFO can accept a word.
- irq  out  1  timer done, level.

Behaviour:
- Register map (address[ADDR_W-1:3]):
  - 0x00 GPIO_OUT: RW.
  - 0x08 GPIO_IN: RO, synchronized.
  - 0x10 RX_DATA: RO; a read pops the FIFO.
  - 0x18 STATUS: RO. bit0 = empty, bit1 = full, bits[7:2] = count, bit8 = timer_done.
  - 0x20 TIMER: RW.
  - Any other address reads 0; writes to it are ignored.
- Reset (reset = 0, asynchronous) clears: data_in, gpio_out, FIFO pointers and count, timer, timer_done, irq, and both synchronizer stages. After reset, rx_ready = 1.
- Writes take effect on the clock edge where Write = 1. Only the low GPIO_WIDTH bits are stored in GPIO_OUT.
- Reads: on an edge with Read = 1, data_in is loaded with the addressed value, giving one-cycle latency. On an edge with Read = 0, data_in loads 0. Read and Write in the same cycle: the write is applied, and data_in returns the pre-write value.
- GPIO_IN: two-flop synchronizer. A change on gpio_in is visible to a read issued 2 cycles later, and zero-extended to 64 bits.
- FIFO handshake:
  - rx_ready = !full.
  - A push happens when rx_valid && rx_ready.
  - A pop happens when Read hits RX_DATA and the FIFO is not empty. data_in returns the head word.
  - Pop on empty: data_in = 0, pointers unchanged.
  - Push and pop in the same cycle (not full, not empty): count unchanged, head advances.
  - When full, rx_ready = 0 even if a pop occurs in the same cycle. A push is refused for that cycle and accepted on the next.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count ranges 0..FIFO_DEPTH.
- TIMER:
  - A write loads Databus[31:0] and clears timer_done.
  - While the count is nonzero it decrements by 1 per cycle.
  - On the 1->0 transition timer_done sets and is sticky. irq = timer_done.
  - Writing 0 leaves the timer idle and timer_done cleared.
  - A write on the same edge as the 1->0 transition wins: the new value loads and done stays 0.
  - A read returns the current count, zero-extended.
- Reset asserted mid-operation aborts all state immediately, without waiting for a clock edge.

Optional Feature:
- Macro: IO_TIMER_EN.
- Defined: the TIMER register, timer_done and irq behave as described above.
- Undefined: no timer logic is built. Address 0x20 reads 0 and ignores writes, STATUS bit8 reads 0, and irq is tied to 0.

Test Plan:
- Reset release: all outputs 0, rx_ready = 1. Write GPIO_OUT = 0xFFFF_0000_0000_ABCD -> gpio_out = 0xABCD. A read of 0x00 returns 0xABCD on data_in the next cycle.
- gpio_in = 0x1234 at cycle n; read GPIO_IN at n+1 -> 0; read at n+2 -> 0x1234.
- Push 4 words 0xA0..0xA3 -> rx_ready = 0 and STATUS = 0x12. Fifth rx_valid is refused. Four RX_DATA reads return 0xA0..0xA3 in order; STATUS then reads 0x01. A fifth read returns 0.
- FIFO holding 2 words: simultaneous push of 0xB0 and pop -> pop returns the oldest word, count stays 2. When full: pop plus rx_valid -> push is refused that cycle and accepted the next.
- Write TIMER = 3 -> irq rises exactly 3 cycles after the write edge. TIMER reads 0 and STATUS bit8 = 1. Writing TIMER = 5 clears irq.
- Assert reset mid-FIFO-fill and mid-countdown -> count = 0, irq = 0 and data_in = 0 immediately, before any clock edge. With IO_TIMER_EN undefined, TIMER reads 0 and irq stays 0.

Source files
------------

// File: rtl/io_bus_responder.sv
// CPU-bus responder: GPIO latch, synchronized GPIO input, RX FIFO, optional one-shot timer.
// Read data is registered (1-cycle latency); rx_ready = !full. Timer built only with IO_TIMER_EN.
module io_bus_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int GPIO_WIDTH = 16,
  parameter int ADDR_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic [63:0]           Databus,
  input  logic                  Write,
  input  logic                  Read,
  output logic [63:0]           data_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  input  logic [63:0]           rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 3;

  logic [WA_W-1:0] waddr;
  logic            sel_gpo, sel_gpi, sel_rx, sel_stat, sel_tmr;

  assign waddr    = address[ADDR_W-1:3];
  assign sel_gpo  = (waddr == WA_W'(0));
  assign sel_gpi  = (waddr == WA_W'(1));
  assign sel_rx   = (waddr == WA_W'(2));
  assign sel_stat = (waddr == WA_W'(3));
  assign sel_tmr  = (waddr == WA_W'(4));

  logic [GPIO_WIDTH-1:0] gpio_out_q, sync1_q, sync2_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [63:0]           data_q, data_d;
  logic [63:0]           mem_q [FIFO_DEPTH];
  logic                  empty, full, push, pop;
  logic [63:0]           timer_rd;
  logic                  timer_done;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign rx_ready = !full;
  // Full blocks the push even if a pop frees a slot on the same edge.
  assign push     = rx_valid && !full;
  assign pop      = Read && sel_rx && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef IO_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic        done_q, done_d;

  // A write on the terminal edge wins over the 1->0 transition.
  always_comb begin
    timer_d = timer_q;
    done_d  = done_q;
    if (Write && sel_tmr) begin
      timer_d = Databus[31:0];
      done_d  = 1'b0;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 32'd1;
      if (timer_q == 32'd1) done_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  assign timer_rd   = {32'b0, timer_q};
  assign timer_done = done_q;
`else
  assign timer_rd   = '0;
  assign timer_done = 1'b0;
`endif

  assign irq = timer_done;

  always_comb begin
    data_d = '0;
    if (Read) begin
      if (sel_gpo)  data_d = 64'(gpio_out_q);
      if (sel_gpi)  data_d = 64'(sync2_q);
      if (sel_rx && !empty) data_d = mem_q[rd_ptr_q];
      if (sel_stat) begin
        data_d[0]   = empty;
        data_d[1]   = full;
        data_d[7:2] = 6'(count_q);
        data_d[8]   = timer_done;
      end
      if (sel_tmr)  data_d = timer_rd;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
    end else begin
      if (Write && sel_gpo) gpio_out_q <= Databus[GPIO_WIDTH-1:0];
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  assign data_in  = data_q;
  assign gpio_out = gpio_out_q;

  logic unused_bits;
  assign unused_bits = ^{address[2:0], Databus};

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: directed steps then random traffic, all checked against a
// queue-based behavioural model updated once per clock edge.
module tb_io_bus_responder;
  localparam int DEPTH = 4;
  localparam int GW    = 16;
  localparam int AW    = 8;
`ifdef IO_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [63:0]   Databus;
  logic          Write, Read;
  logic [63:0]   data_in;
  logic [GW-1:0] gpio_out, gpio_in;
  logic [63:0]   rx_data;
  logic          rx_valid, rx_ready, irq;

  always #5 clock = ~clock;

  io_bus_responder #(.FIFO_DEPTH(DEPTH), .GPIO_WIDTH(GW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .address(address), .Databus(Databus),
    .Write(Write), .Read(Read), .data_in(data_in), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0]   q[$];
  logic [GW-1:0] m_gpio, m_s1, m_s2;
  logic [31:0]   m_tmr;
  logic          m_done;
  logic [63:0]   m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ba(input logic [4:0] w);
    logic [2:0] lo;
    lo = 3'($urandom);
    return {w, lo};
  endfunction

  task automatic model_reset();
    q.delete();
    m_gpio = '0; m_s1 = '0; m_s2 = '0;
    m_tmr = '0; m_done = 1'b0; m_data = '0;
  endtask

  function automatic logic [63:0] model_read();
    logic [63:0] v;
    v = '0;
    case (address[7:3])
      5'd0: v = 64'(m_gpio);
      5'd1: v = 64'(m_s2);
      5'd2: v = (q.size() > 0) ? q[0] : 64'd0;
      5'd3: v = {55'd0, m_done, 6'(q.size()), q.size() == DEPTH, q.size() == 0};
      5'd4: v = TMR ? 64'(m_tmr) : 64'd0;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    bit was_full;
    was_full = (q.size() == DEPTH);
    m_data = Read ? model_read() : 64'd0;
    if (Read && address[7:3] == 5'd2 && q.size() > 0) void'(q.pop_front());
    if (rx_valid && !was_full) q.push_back(rx_data);
    if (TMR) begin
      if (Write && address[7:3] == 5'd4) begin
        m_tmr = Databus[31:0];
        m_done = 1'b0;
      end else if (m_tmr != 0) begin
        m_tmr = m_tmr - 1;
        if (m_tmr == 0) m_done = 1'b1;
      end
    end
    if (Write && address[7:3] == 5'd0) m_gpio = Databus[GW-1:0];
    m_s2 = m_s1;
    m_s1 = gpio_in;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check("data_in", data_in, m_data);
    check("gpio_out", 64'(gpio_out), 64'(m_gpio));
    check("rx_ready", 64'(rx_ready), 64'(q.size() != DEPTH));
    check("irq", 64'(irq), 64'(m_done));
  endtask

  task automatic wr(input logic [4:0] w, input logic [63:0] d);
    Write = 1'b1; address = ba(w); Databus = d;
    tick();
    Write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] w, output logic [63:0] v);
    Read = 1'b1; address = ba(w);
    tick();
    Read = 1'b0;
    v = data_in;
  endtask

  task automatic push(input logic [63:0] d);
    rx_valid = 1'b1; rx_data = d;
    tick();
    rx_valid = 1'b0;
  endtask

  // Reset asserted one ns after an edge; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_data_in"}, data_in, 64'd0);
    check({tag, "_irq"}, 64'(irq), 64'd0);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    check({tag, "_gpio_out"}, 64'(gpio_out), 64'd0);
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] v;
    reset = 1'b0; address = '0; Databus = '0; Write = 1'b0; Read = 1'b0;
    gpio_in = '0; rx_data = '0; rx_valid = 1'b0;
    model_reset();
    #12;
    check("rst_data_in", data_in, 64'd0);
    check("rst_gpio_out", 64'(gpio_out), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    reset = 1'b1;

    wr(5'd0, 64'hFFFF_0000_0000_ABCD);
    check("gpio_write", 64'(gpio_out), 64'hABCD);
    rd(5'd0, v);
    check("gpio_readback", v, 64'hABCD);

    gpio_in = 16'h1234;
    tick();
    rd(5'd1, v);
    check("gpio_in_n1", v, 64'd0);
    rd(5'd1, v);
    check("gpio_in_n2", v, 64'h1234);

    for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
    check("full_rx_ready", 64'(rx_ready), 64'd0);
    push(64'hEE);
    rd(5'd3, v);
    check("status_full", v, 64'h12);
    for (int i = 0; i < 4; i++) begin
      rd(5'd2, v);
      check("rx_order", v, 64'hA0 + 64'(i));
    end
    rd(5'd3, v);
    check("status_empty", v, 64'h01);
    rd(5'd2, v);
    check("pop_empty", v, 64'd0);

    push(64'hC0);
    push(64'hC1);
    rx_valid = 1'b1; rx_data = 64'hB0; Read = 1'b1; address = ba(5'd2);
    tick();
    check("push_pop_head", data_in, 64'hC0);
    Read = 1'b0; rx_valid = 1'b0;
    rd(5'd3, v);
    check("push_pop_count", v, 64'h08);
    push(64'hD0);
    push(64'hD1);
    rx_valid = 1'b1; rx_data = 64'hE0; Read = 1'b1; address = ba(5'd2);
    tick();
    check("full_pop_head", data_in, 64'hC1);
    Read = 1'b0; rx_data = 64'hE1;
    tick();
    rx_valid = 1'b0;
    rd(5'd3, v);
    check("refill_status", v, 64'h12);
    for (int i = 0; i < 4; i++) begin
      rd(5'd2, v);
      case (i)
        0: check("drain0", v, 64'hB0);
        1: check("drain1", v, 64'hD0);
        2: check("drain2", v, 64'hD1);
        default: check("drain3", v, 64'hE1);
      endcase
    end

    wr(5'd4, 64'd3);
    tick(); check("tmr_edge1", 64'(irq), 64'd0);
    tick(); check("tmr_edge2", 64'(irq), 64'd0);
    tick(); check("tmr_edge3", 64'(irq), 64'(TMR));
    rd(5'd4, v);
    check("tmr_read_zero", v, 64'd0);
    rd(5'd3, v);
    check("status_done", v, TMR ? 64'h101 : 64'h001);
    wr(5'd4, 64'd5);
    check("tmr_reload_clears", 64'(irq), 64'd0);
    wr(5'd4, 64'd2);
    tick();
    wr(5'd4, 64'd7);
    check("tmr_write_wins", 64'(irq), 64'd0);
    rd(5'd4, v);
    check("tmr_reload_val", v, TMR ? 64'd7 : 64'd0);

    wr(5'd4, 64'd2);
    for (int i = 0; i < 4; i++) push(64'hF0 + 64'(i));
    rd(5'd0, v);
    do_reset("rstA");
    tick();
    rd(5'd3, v);
    check("rstA_status", v, 64'h01);

    wr(5'd0, 64'h77);
    wr(5'd4, 64'd50);
    push(64'h11);
    push(64'h22);
    rd(5'd0, v);
    do_reset("rstB");
    tick();
    rd(5'd4, v);
    check("rstB_timer", v, 64'd0);
    rd(5'd3, v);
    check("rstB_status", v, 64'h01);

    for (int i = 0; i < 400; i++) begin
      Read     = 1'($urandom_range(0, 1));
      Write    = ($urandom_range(0, 3) == 0);
      address  = ba(($urandom_range(0, 1) == 1) ? 5'd2 : 5'($urandom_range(0, 6)));
      Databus  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) Databus[31:0] = 32'($urandom_range(0, 12));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = {$urandom, $urandom};
      gpio_in  = GW'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
